sram_nr1w_clr: RTL
==================

Name: sram_nr1w_clr

Overview:
Parameterised multi-read-port, single-write-port synchronous SRAM for LeNet feature-map and weight buffering. It adds the following to the basic 1R1W array:
- NUM_RD independent read ports.
- Per-lane write masking.
- Selectable read latency.
- A defined read-during-write policy.
- A sequential clear engine that zeroes the array one word per cycle after reset or on request. The array itself is never reset in a single cycle.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 8, address width
DATA_DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
RD_LAT, 1, read latency in cycles; legal values are 1 or 2
WE_GRAN, 8, bits per write-mask lane; DATA_WIDTH must be a multiple of WE_GRAN
RDW_MODE, 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data bypassed)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset, asynchronous, active-low
csen  in  1  chip select, active high; gates user reads and writes
clr_req  in  1  request to zero the whole array
busy  out  1  high while the clear sweep runs
wr_en  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH/WE_GRAN  per-lane write enable; bit k covers bits [k*WE_GRAN +: WE_GRAN]
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i uses [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  packed read data
rd_valid  out  NUM_RD  per-port one-cycle pulse marking new rd_data

Behaviour:
- Reset (asynchronous, active-low):
  - rd_data = 0, rd_valid = 0, and all RD_LAT pipeline registers are cleared.
  - busy = 1; FSM state = CLEAR; clear address = 0.
  - Array contents are not reset directly.
- Clear FSM, two states:
  - CLEAR: each edge writes 0 to mem[clr_addr], then clr_addr increments.
  - At clr_addr == DATA_DEPTH-1: the last word is written, the FSM goes to IDLE and busy falls at that edge.
  - busy is therefore high for exactly DATA_DEPTH cycles after reset release or after clear entry.
  - IDLE: if clr_req = 1 at an edge, go to CLEAR with clr_addr = 0; busy rises at that same edge.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
  - The sweep runs regardless of csen.
- While busy = 1:
  - User writes are dropped.
  - User reads are not accepted: no rd_valid, and rd_data holds.
  - Reads accepted before the clear began still complete their pipeline.
- Write:
  - Condition: csen & wr_en & ~busy at an edge.
  - Each lane k with wr_mask[k] = 1 takes the new data; unmasked lanes keep their old value.
  - wr_addr >= DATA_DEPTH: the write is ignored.
- Read on port i:
  - Accepted when csen & rd_en[i] & ~busy at edge T.
  - RD_LAT = 1: rd_data[i] updates and rd_valid[i] = 1 at edge T, visible during cycle T+1.
  - RD_LAT = 2: one extra output register; data and valid appear one cycle later.
  - When no read is accepted, rd_valid[i] = 0 and rd_data[i] holds its last value.
  - rd_addr >= DATA_DEPTH: returns 0 with rd_valid = 1.
  - Ports are fully independent; identical addresses on several ports are legal and return identical data.
- Read-during-write, same address, same edge:
  - RDW_MODE = 0: all lanes return the old word.
  - RDW_MODE = 1: masked lanes return wr_data; unmasked lanes return the old word.
  - Different addresses: no interaction.
- Reset mid-operation: an assertion during a sweep or with reads in flight aborts everything. Outputs return to their reset values, and a full sweep restarts after release.
- Synthesis: the array must infer as memory; no reset or clear loop is applied to the array in one cycle.

Test Plan:
- Reset release -> busy = 1 for exactly 256 cycles, then 0. Read port 0 at addr 0x37 -> rd_data = 0x00, rd_valid pulse 1 cycle later (RD_LAT = 1).
- Write 0xA5 to addr 0x10 with mask 1, then read 0x10 on both ports in the same cycle -> both rd_data = 0xA5, both rd_valid = 1 for one cycle.
- DATA_WIDTH = 16, WE_GRAN = 8: write 0x1234 to addr 5, then write 0xABCD with mask 2'b10 -> read returns 0xAB34.
- Write 0x5A to addr 3 (old value 0x11) while reading addr 3 on the same edge -> RDW_MODE = 0 returns 0x11; RDW_MODE = 1 returns 0x5A. Repeat with RD_LAT = 2 -> data arrives one cycle later.
- csen = 0 with wr_en = 1 and rd_en = 2'b11 -> memory unchanged, rd_valid = 0, rd_data held.
- clr_req pulse in IDLE after writing 0xFF to addr 0xFE -> busy high 256 cycles; writes and reads during busy are ignored; addr 0xFE afterwards reads 0x00. rst_n pulsed at cycle 100 of the sweep -> rd_data = 0, and busy is high again for a full 256 cycles.

Source files
------------

// File: rtl/sram_nr1w_clr.sv
// ---------------------------------------------------------------------------
// sram_nr1w_clr
//   Multi-read-port, single-write-port synchronous SRAM used to buffer LeNet
//   feature maps and weights.
//
//   - NUM_RD independent read ports with a 1- or 2-cycle registered read.
//   - One write port with per-lane write masking (WE_GRAN bits per lane).
//   - Read-during-write at the same address is either read-first
//     (RDW_MODE = 0) or write-first with masked-lane bypass (RDW_MODE = 1).
//   - A clear engine zeroes the array one word per cycle. It runs after reset
//     and whenever clr_req is seen while idle. The array itself is never
//     reset, so it still maps onto block RAM.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset (control and output registers only)
//   csen      chip select, gates user reads and writes
//   clr_req   start a clear sweep (only honoured while idle)
//   busy      high while the clear sweep runs; user traffic is ignored then
//   wr_en     write enable
//   wr_addr   write address (addresses >= DATA_DEPTH are dropped)
//   wr_data   write data
//   wr_mask   per-lane write enable, bit k covers [k*WE_GRAN +: WE_GRAN]
//   rd_en     per-port read enable
//   rd_addr   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid  per-port one-cycle pulse marking fresh rd_data
// ---------------------------------------------------------------------------
module sram_nr1w_clr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    parameter int NUM_RD     = 2,
    parameter int RD_LAT     = 1,
    parameter int WE_GRAN    = 8,
    parameter int RDW_MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           csen,
    input  logic                           clr_req,
    output logic                           busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/WE_GRAN-1:0]  wr_mask,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_valid
);

    localparam int NUM_LANES = DATA_WIDTH / WE_GRAN;
    // Array index width; narrower than ADDR_WIDTH when the array does not
    // fill the whole address space. Upper address bits only feed the range
    // checks.
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DATA_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
    logic              clr_we;

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    // -----------------------------------------------------------------------
    // Clear FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Clear FSM: next state. The sweep cannot be restarted by clr_req once it
    // is running; only reset restarts it.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Clear FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy   = (state_q == ST_CLEAR);
        clr_we = (state_q == ST_CLEAR);
    end

    // -----------------------------------------------------------------------
    // Write port. The clear engine and the user share the single physical
    // write port. They never compete, because user writes are dropped while
    // busy.
    // -----------------------------------------------------------------------
    logic                  user_wr;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_LANES-1:0]  mem_lane_en;

    always_comb begin
        user_wr = csen & wr_en & ~busy & ({1'b0, wr_addr} < DEPTH_EXT);
        mem_we  = clr_we | user_wr;
        if (clr_we) begin
            mem_widx    = clr_addr_q;
            mem_wdata   = '0;
            mem_lane_en = '1;
        end else begin
            mem_widx    = wr_addr[IDX_W-1:0];
            mem_wdata   = wr_data;
            mem_lane_en = wr_mask;
        end
    end

    // Lane-enabled write with no reset, so the array maps to RAM with byte
    // enables.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (mem_lane_en[k]) begin
                    mem[mem_widx][k*WE_GRAN +: WE_GRAN] <= mem_wdata[k*WE_GRAN +: WE_GRAN];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  rd_acc;
        logic                  rdw_hit;
        logic [DATA_WIDTH-1:0] rd_word;
        logic                  s1_valid_q;
        logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

        always_comb begin
            raddr   = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            rd_acc  = csen & rd_en[gi] & ~busy;
            rd_word = '0;
            // Out-of-range addresses read as zero instead of aliasing.
            if ({1'b0, raddr} < DEPTH_EXT) begin
                rd_word = mem[raddr[IDX_W-1:0]];
            end
            // Write-first bypass. Only the lanes actually written this edge
            // take the new data; the rest still show the stored word.
            rdw_hit = (RDW_MODE == 1) && user_wr && (raddr == wr_addr);
            for (int k = 0; k < NUM_LANES; k++) begin
                if (rdw_hit && wr_mask[k]) begin
                    rd_word[k*WE_GRAN +: WE_GRAN] = wr_data[k*WE_GRAN +: WE_GRAN];
                end
            end
            // Hold the last returned word when no read is accepted.
            s1_data_d = rd_acc ? rd_word : s1_data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_acc;
                s1_data_q  <= s1_data_d;
            end
        end

        if (RD_LAT == 1) begin : g_lat1
            assign rd_valid[gi]                          = s1_valid_q;
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH]  = s1_data_q;
        end else begin : g_lat2
            // Extra output register. It only loads when stage 1 carries a
            // fresh word, so the output holds between reads.
            logic                  s2_valid_q;
            logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

            always_comb begin
                s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign rd_valid[gi]                          = s2_valid_q;
            assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH]  = s2_data_q;
        end
    end

endmodule
